// File: rtl/tpu_frame_tx_if.sv
// Payload stream and SPI-style bus of the TPU host frame transmitter.
// master = transmitter side, slave = payload source / bus receiver.
interface tpu_frame_tx_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  pl_valid;
  logic [DATA_WIDTH-1:0] pl_data;
  logic                  pl_ready;
  logic                  clk_out;
  logic                  sel_out;
  logic [DATA_WIDTH-1:0] data_out;

  modport master (
    input  pl_valid, pl_data,
    output pl_ready, clk_out, sel_out, data_out
  );

  modport slave (
    output pl_valid, pl_data,
    input  pl_ready, clk_out, sel_out, data_out
  );
endinterface

// File: rtl/tpu_frame_tx.sv
// Host-side frame transmitter: header byte + grid/move payload
// driven onto the clk/sel/data bus sampled by the TPU SPI receiver.
module tpu_frame_tx #(
  parameter int DATA_WIDTH = 8,
  parameter int BIT_DUR    = 2,
  parameter int GRID_BYTES = 64,
  parameter int MAX_MOVES  = 220,
  parameter logic [DATA_WIDTH-1:0] GRID_HEADER = 8'b11_01_01_01,
  parameter logic [DATA_WIDTH-1:0] MOVE_HEADER = 8'b11_10_10_10
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       start,
  input  logic       kind,
  input  logic [7:0] n_moves,
  output logic       busy,
  output logic       done,
  output logic       err,
  tpu_frame_tx_if.master tx
);
  localparam int LMAX = (GRID_BYTES > 2 * MAX_MOVES) ?
                        GRID_BYTES : 2 * MAX_MOVES;
  localparam int CW = $clog2(LMAX + 1);
  localparam int PW = $clog2(2 * BIT_DUR);

  typedef enum logic [2:0] {
    IDLE, SLOT_LO, SLOT_HI, WAIT, GAP
  } state_t;

  state_t                state, state_n;
  logic [PW-1:0]         ph, ph_n;
  logic [CW-1:0]         rem, rem_n;
  logic [DATA_WIDTH-1:0] data_q, data_n;
  logic                  err_q, err_n;
  logic                  pl_ready;
  logic                  slot_end, gap_end;

  assign slot_end = (ph == PW'(BIT_DUR - 1));
  assign gap_end  = (ph == PW'(2 * BIT_DUR - 1));

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state  <= IDLE;
      ph     <= '0;
      rem    <= '0;
      data_q <= '0;
      err_q  <= 1'b0;
    end else begin
      state  <= state_n;
      ph     <= ph_n;
      rem    <= rem_n;
      data_q <= data_n;
      err_q  <= err_n;
    end
  end

  always_comb begin
    state_n  = state;
    ph_n     = ph;
    rem_n    = rem;
    data_n   = data_q;
    err_n    = 1'b0;
    pl_ready = 1'b0;
    done     = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          if (kind && (int'(n_moves) > MAX_MOVES)) begin
            err_n = 1'b1;
          end else begin
            state_n = SLOT_LO;
            ph_n    = '0;
            data_n  = kind ? MOVE_HEADER : GRID_HEADER;
            rem_n   = kind ? CW'({n_moves, 1'b0})
                           : CW'(GRID_BYTES);
          end
        end
      end
      SLOT_LO: begin
        if (slot_end) begin
          state_n = SLOT_HI;
          ph_n    = '0;
        end else begin
          ph_n = ph + 1'b1;
        end
      end
      SLOT_HI: begin
        if (!slot_end) begin
          ph_n = ph + 1'b1;
        end else begin
          // last high cycle: fetch the next byte or close the frame
          ph_n = '0;
          if (rem != '0) begin
            pl_ready = 1'b1;
            if (tx.pl_valid) begin
              data_n  = tx.pl_data;
              rem_n   = rem - 1'b1;
              state_n = SLOT_LO;
            end else begin
              state_n = WAIT;
            end
          end else begin
            data_n  = '0;
            state_n = GAP;
          end
        end
      end
      WAIT: begin
        pl_ready = 1'b1;
        if (tx.pl_valid) begin
          data_n  = tx.pl_data;
          rem_n   = rem - 1'b1;
          ph_n    = '0;
          state_n = SLOT_LO;
        end
      end
      GAP: begin
        if (gap_end) begin
          done    = 1'b1;
          ph_n    = '0;
          state_n = IDLE;
        end else begin
          ph_n = ph + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign busy        = (state != IDLE);
  assign err         = err_q;
  assign tx.pl_ready = pl_ready;
  assign tx.clk_out  = (state == SLOT_HI);
  assign tx.sel_out  = !((state == SLOT_LO) ||
                         (state == SLOT_HI) ||
                         (state == WAIT));
  assign tx.data_out = data_q;
endmodule

// File: tb/tb_tpu_frame_tx.sv
// Scoreboard bench for tpu_frame_tx: expected bus bytes are queued
// at stimulus time and popped on every rising clk_out.
module tb_tpu_frame_tx;
  logic       clk = 1'b0;
  logic       nrst;
  logic       start;
  logic       kind;
  logic [7:0] n_moves;
  logic       busy, done, err;

  tpu_frame_tx_if #(.DATA_WIDTH(8)) bus ();

  tpu_frame_tx dut (
    .clk     (clk),
    .nrst    (nrst),
    .start   (start),
    .kind    (kind),
    .n_moves (n_moves),
    .busy    (busy),
    .done    (done),
    .err     (err),
    .tx      (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  logic [7:0] pay_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] last_byte = '0;

  int edge_cnt, hs_cnt, busy_cnt, sel_cnt;
  int done_cnt, err_cnt, stall_seen;
  int stall_at = -1;
  bit hs_pend  = 1'b0;
  bit prev_clk = 1'b0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clr();
    edge_cnt   = 0;
    hs_cnt     = 0;
    busy_cnt   = 0;
    sel_cnt    = 0;
    done_cnt   = 0;
    err_cnt    = 0;
    stall_seen = 0;
  endtask

  // monitor + scoreboard, sampled mid-cycle
  always @(negedge clk) begin
    if (busy) busy_cnt++;
    if (!bus.sel_out) sel_cnt++;
    if (done) done_cnt++;
    if (err) err_cnt++;
    if (bus.pl_ready && !bus.pl_valid && stall_at == hs_cnt) begin
      if (stall_seen > 0) begin
        chk("stall_clk", bus.clk_out, 0);
        chk("stall_sel", bus.sel_out, 0);
        chk("stall_data", bus.data_out, last_byte);
      end
      stall_seen++;
    end
    hs_pend = bus.pl_ready && bus.pl_valid;
    if (hs_pend) hs_cnt++;
    if (bus.clk_out && !prev_clk) begin
      edge_cnt++;
      if (exp_q.size() > 0)
        chk("bus_byte", bus.data_out, exp_q.pop_front());
      else
        chk("extra_edge", bus.data_out, 32'hDEAD);
    end
    prev_clk = bus.clk_out;
  end

  // payload source
  initial begin
    bus.pl_valid = 1'b0;
    bus.pl_data  = '0;
    forever begin
      @(posedge clk);
      #1;
      if (hs_pend && pay_q.size() > 0)
        last_byte = pay_q.pop_front();
      bus.pl_valid = (pay_q.size() > 0) &&
                     !(stall_at == hs_cnt && stall_seen < 10);
      bus.pl_data  = bus.pl_valid ? pay_q[0] : 8'h00;
    end
  end

  task automatic push_pay(input logic [7:0] b);
    pay_q.push_back(b);
    exp_q.push_back(b);
  endtask

  task automatic go(input logic k, input logic [7:0] n);
    @(posedge clk);
    #1;
    clr();
    start   = 1'b1;
    kind    = k;
    n_moves = n;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    chk("done_timeout", n < budget, 1);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic end_frame(input int e, input int h);
    chk("edges", edge_cnt, e);
    chk("handshakes", hs_cnt, h);
    chk("done_pulses", done_cnt, 1);
    chk("err_pulses", err_cnt, 0);
    chk("queue_left", exp_q.size(), 0);
    chk("busy_after", busy, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    int n;
    nrst    = 1'b0;
    start   = 1'b0;
    kind    = 1'b0;
    n_moves = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_clk", bus.clk_out, 0);
    chk("rst_sel", bus.sel_out, 1);
    chk("rst_data", bus.data_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", bus.pl_ready, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    nrst = 1'b1;

    // full grid frame, no stalls
    exp_q.push_back(8'hD5);
    for (int i = 0; i < 64; i++) push_pay(8'(i));
    go(1'b0, 8'd0);
    wait_done(400);
    end_frame(65, 64);
    chk("grid_sel_low", sel_cnt, 65 * 4);
    chk("grid_busy", busy_cnt, 65 * 4 + 4);

    // three moves
    exp_q.push_back(8'hEA);
    for (int i = 0; i < 6; i++) push_pay(8'hA1 + 8'(i));
    go(1'b1, 8'd3);
    wait_done(100);
    end_frame(7, 6);

    // one move, source stalls before its second byte
    stall_at = 1;
    exp_q.push_back(8'hEA);
    push_pay(8'hB1);
    push_pay(8'hB2);
    go(1'b1, 8'd1);
    wait_done(100);
    end_frame(3, 2);
    chk("stall_cycles", stall_seen, 10);
    stall_at = -1;

    // header only
    exp_q.push_back(8'hEA);
    go(1'b1, 8'd0);
    wait_done(50);
    end_frame(1, 0);
    chk("hdr_busy", busy_cnt, 8);

    // too many moves
    go(1'b1, 8'd221);
    repeat (6) @(posedge clk);
    #1;
    chk("rej_err", err_cnt, 1);
    chk("rej_busy", busy_cnt, 0);
    chk("rej_sel", sel_cnt, 0);
    chk("rej_edges", edge_cnt, 0);

    // largest legal move list
    exp_q.push_back(8'hEA);
    for (int i = 0; i < 440; i++) push_pay(8'(i * 7));
    go(1'b1, 8'd220);
    wait_done(3000);
    end_frame(441, 440);

    // reset during the 5th payload byte of a grid frame
    exp_q.push_back(8'hD5);
    for (int i = 0; i < 64; i++) push_pay(8'(i * 3 + 1));
    go(1'b0, 8'd0);
    n = 0;
    while (hs_cnt < 5 && n < 200) begin
      @(posedge clk);
      n++;
    end
    chk("hs5_timeout", n < 200, 1);
    #1;
    nrst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("abort_clk", bus.clk_out, 0);
    chk("abort_sel", bus.sel_out, 1);
    chk("abort_data", bus.data_out, 0);
    chk("abort_busy", busy, 0);
    nrst = 1'b1;
    pay_q.delete();
    exp_q.delete();
    repeat (10) @(posedge clk);
    #1;
    chk("abort_done", done_cnt, 0);
    chk("abort_idle", busy, 0);

    // fresh grid frame after the abort
    exp_q.push_back(8'hD5);
    for (int i = 0; i < 64; i++) push_pay(8'hFF - 8'(i));
    go(1'b0, 8'd0);
    wait_done(400);
    end_frame(65, 64);

    // start while busy is ignored
    exp_q.push_back(8'hEA);
    for (int i = 0; i < 4; i++) push_pay(8'hC1 + 8'(i));
    go(1'b1, 8'd2);
    repeat (5) @(posedge clk);
    #1;
    start = 1'b1;
    kind  = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(100);
    end_frame(5, 4);

    // next request after done is accepted
    exp_q.push_back(8'hEA);
    push_pay(8'hD1);
    push_pay(8'hD2);
    go(1'b1, 8'd1);
    wait_done(100);
    end_frame(3, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
